key_schedule_ctrl: RTL

Sequencer for the KeyExpansion round-key datapath (AES-128).
- Accepts a 128-bit cipher key on a start handshake.
- Steps KeyExpansion through rounds 1..10, feeding each round key back as the next input.
- Stores all 11 round keys (round 0 = cipher key) in a local key store.
- The cipher round engine reads the store by round index through a registered read port.

---
 rtl/aes_pkg.sv | 17 +
 rtl/key_store_rf.sv | 49 ++++
 rtl/key_schedule_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types and constants.
// Used by key_schedule_ctrl and key_store_rf.
package aes_pkg;

  localparam int AES_KEY_W     = 128;
  localparam int AES128_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    DONE
  } ks_state_t;

  typedef logic [0:AES_KEY_W-1] key_t;

endpackage

// File: rtl/key_store_rf.sv
// Round-key register file: DEPTH x KEY_W, one write port, registered read.
// KEYSCHED_ZEROIZE_EN adds clearing of stored keys on reset and on start.
module key_store_rf
  import aes_pkg::*;
#(
  parameter int DEPTH = AES128_ROUNDS + 1,
  parameter int KEY_W = AES_KEY_W
) (
  input  logic             clk,
  input  logic             rst,
`ifdef KEYSCHED_ZEROIZE_EN
  input  logic             clr,
`endif
  input  logic             we,
  input  logic [3:0]       wa,
  input  logic [0:KEY_W-1] wd,
  input  logic [3:0]       ra,
  output logic [0:KEY_W-1] rd
);

  localparam logic [3:0] LAST = 4'(DEPTH - 1);

  logic [0:KEY_W-1] mem [DEPTH];

`ifdef KEYSCHED_ZEROIZE_EN
  // clr wipes rounds 1..; entry 0 takes the new key in the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (clr) begin
        for (int i = 1; i < DEPTH; i++) mem[i] <= '0;
      end
      if (we && wa <= LAST) mem[wa] <= wd;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (we && wa <= LAST) mem[wa] <= wd;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)               rd <= '0;
    else if (ra <= LAST)   rd <= mem[ra];
    else                   rd <= '0;
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 KeyExpansion sequencer with an 11-entry round-key store.
// Optional macro KEYSCHED_ZEROIZE_EN: zeroize the store on reset/start.
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int KEY_W      = AES_KEY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:KEY_W-1] key_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  output logic [3:0]       kexp_round_num,
  output logic [0:KEY_W-1] kexp_key,
  input  logic [0:KEY_W-1] kexp_round_key,
  input  logic [3:0]       rd_addr,
  output logic [0:KEY_W-1] rd_key
);

  localparam logic [3:0] LAST_R = 4'(NUM_ROUNDS);

  ks_state_t state, state_nxt;

  logic             accept;
  logic             capture;
  logic             last;
  logic             we;
  logic [3:0]       wa;
  logic [0:KEY_W-1] wd;

  assign last = (kexp_round_num == LAST_R);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        busy      = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        busy      = 1'b1;
        capture   = 1'b1;
        state_nxt = last ? DONE : ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round number doubles as the store write index.
  always_ff @(posedge clk) begin
    if (rst) begin
      kexp_round_num <= '0;
      kexp_key       <= '0;
      keys_valid     <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        kexp_key       <= key_in;
        kexp_round_num <= 4'd1;
        keys_valid     <= 1'b0;
      end else if (capture) begin
        kexp_key <= kexp_round_key;
        if (last) begin
          done       <= 1'b1;
          keys_valid <= 1'b1;
        end else begin
          kexp_round_num <= kexp_round_num + 4'd1;
        end
      end
    end
  end

  assign we = accept | capture;
  assign wa = accept ? 4'd0 : kexp_round_num;
  assign wd = accept ? key_in : kexp_round_key;

  key_store_rf #(
    .DEPTH (NUM_ROUNDS + 1),
    .KEY_W (KEY_W)
  ) u_store (
    .clk (clk),
    .rst (rst),
`ifdef KEYSCHED_ZEROIZE_EN
    .clr (accept),
`endif
    .we  (we),
    .wa  (wa),
    .wd  (wd),
    .ra  (rd_addr),
    .rd  (rd_key)
  );

endmodule
